regwrite_trace_buffer: RTL and testbench
========================================

Name: regwrite_trace_buffer

Overview:
- Debug trace FIFO downstream of the multicycle MIPS core.
- Snoops the core's register-file writeback outputs (RegWrite, WriteRegister, WriteDataReg, PC, Estado).
- Records one entry per committed register write.
- A testbench or debug host drains entries through a valid/ready pop interface. The block never back-pressures the core; when full it drops entries and counts them.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- SKIP_R0, 1: when 1, writes to register 0 are not recorded.
- DROP_W, 16: width of the saturating drop counter.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable; sampled each cycle.
- clear  input  1  synchronous flush; empties FIFO, zeroes dropped, clears overflow.
- RegWrite  input  1  core register-file write strobe.
- WriteRegister  input  5  destination register number.
- WriteDataReg  input  32  value being written.
- PC  input  32  core PC at the write cycle.
- Estado  input  8  core control-state code at the write cycle.
- trace_valid  output  1  head entry available.
- trace_ready  input  1  consumer accepts head entry.
- trace_pc  output  32  head entry PC.
- trace_reg  output  5  head entry register number.
- trace_data  output  32  head entry write data.
- trace_state  output  8  head entry state code.
- count  output  log2(DEPTH)+1  current occupancy.
- dropped  output  DROP_W  entries lost while full; saturates at all-ones.
- overflow  output  1  sticky; set on first drop.

Behaviour:
- Reset (reset=0, asynchronous): read/write pointers = 0, count = 0, trace_valid = 0, trace_pc/trace_reg/trace_data/trace_state = 0, dropped = 0, overflow = 0.
  - Storage array contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Capture condition, evaluated at each rising Clk: push_req = enable & RegWrite & !(SKIP_R0 & WriteRegister==0).
  - The sampled fields {PC, WriteRegister, WriteDataReg, Estado} form one entry.
  - RegWrite held high for N consecutive cycles produces N entries; there is no edge detection.
- Pop:
  - pop = trace_valid & trace_ready at the rising edge.
  - trace_* outputs always present the head entry, registered from storage.
  - trace_valid = (count != 0).
  - trace_valid and the head data must stay stable until popped.
- Latency: an entry pushed at edge k gives trace_valid=1 after edge k when the FIFO was empty. It can be popped at edge k+1 at the earliest; there is no same-cycle bypass.
- Simultaneous events:
  - Push and pop, not full: both occur; count unchanged.
  - Push and pop while full: the pop frees a slot, the push is accepted, count stays DEPTH, no drop.
  - Push while full without pop: entry discarded, dropped += 1 (saturating at 2^DROP_W-1), overflow set to 1.
  - Pop while empty: ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is derived from, or kept consistent with, the pointers; full = (count==DEPTH).
- clear has priority over push and pop in the same cycle. After the edge: count=0, trace_valid=0, dropped=0, overflow=0. The push in that cycle is lost and is not counted as a drop.
- enable=0 blocks only capture; pops continue normally.
- No combinational path from RegWrite or WriteRegister to trace_valid.

Test Plan:
- Single capture: reset, enable=1. One cycle with RegWrite=1, WriteRegister=8, WriteDataReg=0x0000_00FF, PC=0x0000_0010, Estado=0x05, trace_ready=0 -> next cycle trace_valid=1, trace_reg=8, trace_data=0xFF, trace_pc=0x10, trace_state=0x05, count=1.
- R0 filter: SKIP_R0=1, write to reg 0 value 0x1234 -> count stays 0, trace_valid=0. With SKIP_R0=0 the same write gives count=1.
- Fill and overflow: DEPTH=16, 20 consecutive writes (reg 1..20, data=reg*3), trace_ready=0 -> count=16, dropped=4, overflow=1. Draining yields regs 1..16 in order, then trace_valid=0.
- Full with simultaneous push/pop: FIFO full, one cycle with RegWrite=1 (reg 9, data 0xAA) and trace_ready=1 -> count stays 16, dropped unchanged. 0xAA emerges as the 16th subsequent pop.
- Wrap-around streaming: trace_ready=1 continuously, 40 writes with data 0..39 -> 40 pops in order, data 0..39, count never exceeds 1, dropped=0.
- Clear and async reset: clear pulsed with RegWrite=1 on a non-empty FIFO -> count=0, dropped=0, overflow=0, that write not recorded. Separately, reset driven low between clock edges with count=5 -> trace_valid=0 and count=0 before the next edge.

Source files
------------

// File: rtl/regwrite_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : regwrite_trace_buffer_if
//  Description : Pop-side handshake bundle of the register-write trace FIFO.
//                The master drives the head entry and valid; the slave
//                (debug host / testbench) drives ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regwrite_trace_buffer_if;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [4:0]  trace_reg;
   logic [31:0] trace_data;
   logic [7:0]  trace_state;

   modport master (
      output trace_valid,
      output trace_pc,
      output trace_reg,
      output trace_data,
      output trace_state,
      input  trace_ready
   );

   modport slave (
      input  trace_valid,
      input  trace_pc,
      input  trace_reg,
      input  trace_data,
      input  trace_state,
      output trace_ready
   );
endinterface
`default_nettype wire

// File: rtl/regwrite_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : regwrite_trace_buffer
//  Description : Debug trace FIFO snooping the multicycle MIPS core register
//                writeback. One entry per committed register write, drained
//                through a valid/ready pop port. Never stalls the core: when
//                full, new entries are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module regwrite_trace_buffer #(
   parameter int DEPTH   = 16,
   parameter bit SKIP_R0 = 1'b1,
   parameter int DROP_W  = 16
) (
   input  wire logic                     Clk,
   input  wire logic                     reset,
   input  wire logic                     enable,
   input  wire logic                     clear,
   input  wire logic                     RegWrite,
   input  wire logic [4:0]               WriteRegister,
   input  wire logic [31:0]              WriteDataReg,
   input  wire logic [31:0]              PC,
   input  wire logic [7:0]               Estado,
   regwrite_trace_buffer_if.master       trace,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DROP_W-1:0]             dropped,
   output logic                          overflow
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;
   localparam int c_ew = 32 + 5 + 32 + 8;
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
   localparam logic [c_cw-1:0] c_one   = c_cw'(1);
   localparam logic [c_cw-1:0] c_zero  = '0;

   // Entry layout: {pc, reg, data, state}
   logic [c_ew-1:0]   r_mem [DEPTH];
   logic [c_aw-1:0]   r_wr_ptr;
   logic [c_aw-1:0]   r_rd_ptr;
   logic [c_cw-1:0]   r_count;
   logic [DROP_W-1:0] r_dropped;
   logic              r_overflow;
   logic [c_ew-1:0]   r_head;

   logic              w_is_filtered;
   logic              w_push_req;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_bypass;
   logic [c_aw-1:0]   w_rd_next;
   logic [c_aw-1:0]   w_wr_next;
   logic [c_cw-1:0]   w_count_next;
   logic [c_ew-1:0]   w_entry_in;
   logic [c_ew-1:0]   w_head_next;

   // Register-0 writes are architecturally void on MIPS; optionally ignore them
   if (SKIP_R0) begin : g_skip_r0
      assign w_is_filtered = (WriteRegister == 5'd0);
   end else begin : g_keep_r0
      assign w_is_filtered = 1'b0;
   end

   // Push/pop decisions, next pointers and next head entry
   always_comb begin
      w_entry_in   = {PC, WriteRegister, WriteDataReg, Estado};
      w_push_req   = enable & RegWrite & ~w_is_filtered;
      w_full       = (r_count == c_depth);
      w_pop        = (r_count != c_zero) & trace.trace_ready;
      // A pop while full frees the slot the push lands in
      w_push       = w_push_req & (~w_full | w_pop);
      w_drop       = w_push_req & w_full & ~w_pop;
      w_rd_next    = w_pop  ? r_rd_ptr + c_aw'(1) : r_rd_ptr;
      w_wr_next    = w_push ? r_wr_ptr + c_aw'(1) : r_wr_ptr;
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + c_one;
         2'b01:   w_count_next = r_count - c_one;
         default: w_count_next = r_count;
      endcase
      // The incoming entry becomes the head when nothing older survives this edge
      w_bypass     = w_push & (r_count == (w_pop ? c_one : c_zero));
      w_head_next  = w_bypass ? w_entry_in : r_mem[w_rd_next];
   end

   // Storage array; contents are meaningless until a slot is written
   always_ff @(posedge Clk) begin
      if (w_push && !clear) begin
         r_mem[r_wr_ptr] <= w_entry_in;
      end
   end

   // Pointers, occupancy, drop accounting and the registered head entry
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_dropped  <= '0;
         r_overflow <= 1'b0;
         r_head     <= '0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_dropped  <= '0;
         r_overflow <= 1'b0;
         r_head     <= '0;
      end else begin
         r_wr_ptr <= w_wr_next;
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
         if (w_pop || w_bypass) begin
            r_head <= w_head_next;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropped != {DROP_W{1'b1}}) begin
               r_dropped <= r_dropped + DROP_W'(1);
            end
         end
      end
   end

   assign trace.trace_valid = (r_count != c_zero);
   assign trace.trace_pc    = r_head[c_ew-1 -: 32];
   assign trace.trace_reg   = r_head[44:40];
   assign trace.trace_data  = r_head[39:8];
   assign trace.trace_state = r_head[7:0];
   assign count             = r_count;
   assign dropped           = r_dropped;
   assign overflow          = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_regwrite_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regwrite_trace_buffer
//  Description : Scoreboard bench for regwrite_trace_buffer. Stimulus pushes
//                expected entries into a queue; a monitor compares every pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regwrite_trace_buffer;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rg;
      logic [31:0] data;
      logic [7:0]  st;
   } ent_t;

   logic        Clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic        RegWrite = 1'b0;
   logic [4:0]  WriteRegister = '0;
   logic [31:0] WriteDataReg = '0;
   logic [31:0] PC = '0;
   logic [7:0]  Estado = '0;
   logic        ready = 1'b0;

   logic [4:0]  count0, count1;
   logic [15:0] dropped0, dropped1;
   logic        overflow0, overflow1;

   int   n_checks = 0;
   int   n_fails  = 0;
   int   pop_cnt  = 0;
   ent_t exp_q[$];

   regwrite_trace_buffer_if trc0();
   regwrite_trace_buffer_if trc1();
   assign trc0.trace_ready = ready;
   assign trc1.trace_ready = 1'b0;

   regwrite_trace_buffer #(.DEPTH(16), .SKIP_R0(1'b1), .DROP_W(16)) dut0 (
      .Clk(Clk), .reset(reset), .enable(enable), .clear(clear),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .WriteDataReg(WriteDataReg), .PC(PC), .Estado(Estado),
      .trace(trc0), .count(count0), .dropped(dropped0), .overflow(overflow0)
   );

   regwrite_trace_buffer #(.DEPTH(16), .SKIP_R0(1'b0), .DROP_W(16)) dut1 (
      .Clk(Clk), .reset(reset), .enable(enable), .clear(clear),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .WriteDataReg(WriteDataReg), .PC(PC), .Estado(Estado),
      .trace(trc1), .count(count1), .dropped(dropped1), .overflow(overflow1)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d,
                     input logic [31:0] p, input logic [7:0] s, input bit expect_it);
      ent_t e;
      RegWrite      = 1'b1;
      WriteRegister = r;
      WriteDataReg  = d;
      PC            = p;
      Estado        = s;
      e.pc = p; e.rg = r; e.data = d; e.st = s;
      if (expect_it) exp_q.push_back(e);
   endtask

   // Monitor: every handshake seen before an edge must match the queue head
   always @(negedge Clk) begin
      if (reset && trc0.trace_valid && trc0.trace_ready) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", 32'd1, 32'd0);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("pop_pc",    trc0.trace_pc,          e.pc);
            chk("pop_reg",   {27'd0, trc0.trace_reg}, {27'd0, e.rg});
            chk("pop_data",  trc0.trace_data,        e.data);
            chk("pop_state", {24'd0, trc0.trace_state}, {24'd0, e.st});
            pop_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, 1 expected 0");
      $fatal(1, "watchdog");
   end

   initial begin
      int maxc;
      // Reset state
      step(); step();
      chk("rst_count",    {27'd0, count0}, 32'd0);
      chk("rst_valid",    {31'd0, trc0.trace_valid}, 32'd0);
      chk("rst_dropped",  {16'd0, dropped0}, 32'd0);
      chk("rst_overflow", {31'd0, overflow0}, 32'd0);
      chk("rst_data",     trc0.trace_data, 32'd0);
      reset  = 1'b1;
      enable = 1'b1;
      step();

      // Single capture
      wr(5'd8, 32'h0000_00FF, 32'h0000_0010, 8'h05, 1'b1);
      step();
      RegWrite = 1'b0;
      chk("t1_valid", {31'd0, trc0.trace_valid}, 32'd1);
      chk("t1_reg",   {27'd0, trc0.trace_reg}, 32'd8);
      chk("t1_data",  trc0.trace_data, 32'h0000_00FF);
      chk("t1_pc",    trc0.trace_pc, 32'h0000_0010);
      chk("t1_state", {24'd0, trc0.trace_state}, 32'h05);
      chk("t1_count", {27'd0, count0}, 32'd1);
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("t1_drained", {27'd0, count0}, 32'd0);

      // R0 filter
      clear = 1'b1; step(); clear = 1'b0;
      wr(5'd0, 32'h0000_1234, 32'h0000_0020, 8'h01, 1'b0);
      step();
      RegWrite = 1'b0;
      chk("r0_count_skip", {27'd0, count0}, 32'd0);
      chk("r0_valid_skip", {31'd0, trc0.trace_valid}, 32'd0);
      chk("r0_count_keep", {27'd0, count1}, 32'd1);

      // Fill and overflow
      for (int i = 1; i <= 20; i++) begin
         wr(5'(i), 32'(i * 3), 32'h100 + 32'(4 * i), 8'(i), i <= 16);
         step();
      end
      RegWrite = 1'b0;
      chk("fill_count",    {27'd0, count0}, 32'd16);
      chk("fill_dropped",  {16'd0, dropped0}, 32'd4);
      chk("fill_overflow", {31'd0, overflow0}, 32'd1);

      // Full with simultaneous push and pop
      wr(5'd9, 32'h0000_00AA, 32'h0000_0200, 8'h09, 1'b1);
      ready = 1'b1;
      step();
      RegWrite = 1'b0;
      ready    = 1'b0;
      chk("fullpp_count",   {27'd0, count0}, 32'd16);
      chk("fullpp_dropped", {16'd0, dropped0}, 32'd4);

      // Drain: regs 2..16 then 0xAA
      ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step();
         if (!trc0.trace_valid) break;
      end
      ready = 1'b0;
      chk("drain_valid", {31'd0, trc0.trace_valid}, 32'd0);
      chk("drain_queue", 32'(exp_q.size()), 32'd0);

      // Wrap-around streaming
      clear = 1'b1; step(); clear = 1'b0;
      ready   = 1'b1;
      pop_cnt = 0;
      maxc    = 0;
      for (int i = 0; i < 40; i++) begin
         wr(5'((i % 31) + 1), 32'(i), 32'h400 + 32'(4 * i), 8'h22, 1'b1);
         step();
         if (int'(count0) > maxc) maxc = int'(count0);
      end
      RegWrite = 1'b0;
      step(); step();
      ready = 1'b0;
      chk("stream_maxcount", 32'(maxc), 32'd1);
      chk("stream_pops",     32'(pop_cnt), 32'd40);
      chk("stream_dropped",  {16'd0, dropped0}, 32'd0);
      chk("stream_count",    {27'd0, count0}, 32'd0);

      // Clear with a concurrent write on a non-empty, overflowed FIFO
      for (int i = 1; i <= 17; i++) begin
         wr(5'(i), 32'(i + 100), 32'h800 + 32'(4 * i), 8'h33, i <= 16);
         step();
      end
      RegWrite = 1'b0;
      chk("pre_clear_overflow", {31'd0, overflow0}, 32'd1);
      wr(5'd7, 32'h0000_0777, 32'h0000_0900, 8'h44, 1'b0);
      clear = 1'b1;
      step();
      clear    = 1'b0;
      RegWrite = 1'b0;
      exp_q.delete();
      chk("clr_count",    {27'd0, count0}, 32'd0);
      chk("clr_valid",    {31'd0, trc0.trace_valid}, 32'd0);
      chk("clr_dropped",  {16'd0, dropped0}, 32'd0);
      chk("clr_overflow", {31'd0, overflow0}, 32'd0);
      step();
      chk("clr_write_lost", {27'd0, count0}, 32'd0);

      // Asynchronous reset between edges
      for (int i = 1; i <= 5; i++) begin
         wr(5'(i), 32'(i + 200), 32'hA00 + 32'(4 * i), 8'h55, 1'b1);
         step();
      end
      RegWrite = 1'b0;
      chk("arst_pre_count", {27'd0, count0}, 32'd5);
      @(posedge Clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", {31'd0, trc0.trace_valid}, 32'd0);
      chk("arst_count", {27'd0, count0}, 32'd0);
      chk("arst_data",  trc0.trace_data, 32'd0);
      exp_q.delete();
      step();
      reset = 1'b1;
      step();
      chk("arst_post_count", {27'd0, count0}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
